junction_scheduler: RTL and testbench

Four-way junction phase controller sitting directly downstream of the per-road sensor units (north, east, south, west). It consumes each sensor's 8-bit rolling average of vehicle count, selects the next road in round-robin order, and drives `next_road`, which the sensors use as their sample strobe. Green time scales with the selected road's average, followed by fixed yellow and all-red clearance phases. All timing is counted in `tick` enables, not raw clocks.

---
 rtl/junction_pkg.sv | 12 +
 rtl/junction_phase_timer.sv | 19 +
 rtl/junction_scheduler.sv | 84 ++++++++
 tb/tb_junction_scheduler.sv | 137 +++++++++++++
 4 files changed

// File: rtl/junction_pkg.sv
// junction_pkg: road encodings, phase states and duration width shared by the junction controller.
package junction_pkg;
  localparam logic [1:0] ROAD_N = 2'd0;
  localparam logic [1:0] ROAD_E = 2'd1;
  localparam logic [1:0] ROAD_S = 2'd2;
  localparam logic [1:0] ROAD_W = 2'd3;
  localparam int DUR_W = 9;
  typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW} state_t;
  function automatic logic [3:0] onehot(input logic [1:0] road);
    return 4'b0001 << road;
  endfunction
endpackage

// File: rtl/junction_phase_timer.sv
// phase_timer: 8-bit tick-enabled down-counter, load wins over decrement, done on the last tick.
module phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [7:0] i_val,
  output logic       o_done
);
  logic [7:0] r_count;
  assign o_done = i_tick && r_count == 8'd1;
  always_ff @(posedge clk) begin
    if (reset) r_count <= RST_VAL;
    else if (i_load) r_count <= i_val;
    else if (i_tick) r_count <= r_count - 8'd1;
  end
endmodule

// File: rtl/junction_scheduler.sv
// junction_scheduler: round-robin four-way phase controller; JUNCTION_SKIP_EMPTY_EN skips roads below MIN_DEMAND.
module junction_scheduler
  import junction_pkg::*;
#(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 40,
  parameter int GREEN_SHIFT  = 2,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2
`ifdef JUNCTION_SKIP_EMPTY_EN
  ,parameter int MIN_DEMAND  = 1
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] avg_n,
  input  logic [7:0] avg_e,
  input  logic [7:0] avg_s,
  input  logic [7:0] avg_w,
  output logic [1:0] next_road,
  output logic [1:0] cur_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic       phase_start
);
  state_t           r_state;
  logic [1:0]       r_road, r_next;
  logic [3:0]       r_green, r_yellow, r_red;
  logic             r_ps;
  logic             w_done;
  logic [7:0]       w_avg [4];
  logic [DUR_W-1:0] w_sum;
  logic [7:0]       w_dur, w_val;
  logic [1:0]       w_succ;
  always_comb begin
    w_avg = '{avg_n, avg_e, avg_s, avg_w};
    w_sum = DUR_W'(MIN_GREEN) + DUR_W'(w_avg[r_next] >> GREEN_SHIFT);
    w_dur = (w_sum > DUR_W'(MAX_GREEN)) ? 8'(MAX_GREEN) : w_sum[7:0];
    w_val = r_state == ALL_RED ? w_dur : r_state == GREEN ? 8'(YELLOW_TICKS) : 8'(ALLRED_TICKS);
    w_succ = r_road + 2'd1;
`ifdef JUNCTION_SKIP_EMPTY_EN
    // Scan from farthest to nearest so the nearest qualifying road is the one left standing.
    for (int k = 4; k >= 1; k--)
      if (w_avg[r_road + 2'(k)] >= 8'(MIN_DEMAND)) w_succ = r_road + 2'(k);
`endif
  end
  phase_timer #(.RST_VAL(8'(ALLRED_TICKS))) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_tick (tick),
    .i_load (w_done),
    .i_val  (w_val),
    .o_done (w_done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ALL_RED;
      r_road   <= ROAD_W;
      r_next   <= ROAD_N;
      r_green  <= 4'd0;
      r_yellow <= 4'd0;
      r_red    <= 4'hF;
      r_ps     <= 1'b0;
    end else begin
      r_ps <= w_done && r_state == ALL_RED;
      if (w_done) begin
        r_state  <= r_state == ALL_RED ? GREEN : r_state == GREEN ? YELLOW : ALL_RED;
        r_road   <= r_state == ALL_RED ? r_next : r_road;
        r_next   <= r_state == YELLOW ? w_succ : r_next;
        r_green  <= r_state == ALL_RED ? onehot(r_next) : 4'd0;
        r_yellow <= r_state == GREEN ? onehot(r_road) : 4'd0;
        r_red    <= r_state == ALL_RED ? ~onehot(r_next) : r_state == GREEN ? ~onehot(r_road) : 4'hF;
      end
    end
  end
  assign next_road   = r_next;
  assign cur_road    = r_road;
  assign green       = r_green;
  assign yellow      = r_yellow;
  assign red         = r_red;
  assign phase_start = r_ps;
endmodule

// File: tb/tb_junction_scheduler.sv
// tb_junction_scheduler: table-driven phase-by-phase check of the junction scheduler plus reset and skip sequences.
module tb_junction_scheduler;
  logic       clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic [7:0] avg_n = 8'd20, avg_e = 8'd20, avg_s = 8'd255, avg_w = 8'd1;
  logic [1:0] next_road, cur_road;
  logic [3:0] green, yellow, red;
  logic       phase_start;
  int n_chk = 0, n_fail = 0, per = 1, tcnt = 0;
  typedef struct {
    int         per;
    logic [3:0] g, y;
    logic [1:0] nr;
    int         ticks;
    bit         cc;
  } vec_t;
  vec_t v[$];
  junction_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick),
    .avg_n(avg_n), .avg_e(avg_e), .avg_s(avg_s), .avg_w(avg_w),
    .next_road(next_road), .cur_road(cur_road), .green(green),
    .yellow(yellow), .red(red), .phase_start(phase_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic add(input int p, input logic [3:0] g, input logic [3:0] y, input logic [1:0] nr, input int t, input bit cc);
    vec_t e;
    e.per = p; e.g = g; e.y = y; e.nr = nr; e.ticks = t; e.cc = cc;
    v.push_back(e);
  endtask
  // Called at the negedge of a phase's first cycle; returns at the negedge after the pattern changes.
  task automatic obs(output logic [3:0] g, output logic [3:0] y, output logic [1:0] nr,
                     output int n, output int clks, output int ps, output bit ps_first, output bit bad);
    g = green; y = yellow; nr = next_road; n = 0; clks = 0; ps = 0; ps_first = phase_start; bad = 0;
    while (green == g && yellow == y && next_road == nr && clks < 2000) begin
      if (phase_start) ps++;
      if ((green & yellow) != 0 || red != ~(green | yellow) || $countones(green) > 1 || $countones(yellow) > 1) bad = 1;
      tick = (tcnt % per) == 0;
      tcnt++;
      if (tick) n++;
      clks++;
      @(negedge clk);
    end
  endtask
  task automatic chk_rst();
    chk("rst_next_road", next_road, 0);
    chk("rst_cur_road", cur_road, 3);
    chk("rst_green", green, 0);
    chk("rst_yellow", yellow, 0);
    chk("rst_red", red, 4'hF);
    chk("rst_phase_start", phase_start, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tick = 1'b0;
    @(negedge clk);
    reset = 1'b0; tcnt = 0;
  endtask
  initial begin
    logic [3:0] g, y;
    logic [1:0] nr;
    int n, clks, ps;
    bit psf, bad;
    int d[4] = '{9, 9, 40, 4};
    logic [1:0] seq_e[4];
    logic [1:0] seq_z[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
`ifdef JUNCTION_SKIP_EMPTY_EN
    seq_e = '{2'd0, 2'd2, 2'd3, 2'd0};
`else
    seq_e = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        add(1, 4'd0, 4'd0, 2'(k), 2, 0);
        add(1, 4'b0001 << k, 4'd0, 2'(k), d[k], 0);
        add(1, 4'd0, 4'b0001 << k, 2'(k), 3, 0);
      end
    add(5, 4'd0, 4'd0, 2'd0, 2, 0);
    add(5, 4'b0001, 4'd0, 2'd0, 9, 1);
    add(5, 4'd0, 4'b0001, 2'd0, 3, 1);
    repeat (2) @(negedge clk);
    chk_rst();
    reset = 1'b0;
    avg_n = 8'd20;
    obs(g, y, nr, n, clks, ps, psf, bad);
    chk("first_allred_ticks", n, 2);
    avg_n = 8'd255;
    obs(g, y, nr, n, clks, ps, psf, bad);
    chk("latched_green", g, 4'b0001);
    chk("latched_green_ticks", n, 9);
    avg_n = 8'd20;
    do_reset();
    for (int i = 0; i < v.size(); i++) begin
      if (v[i].per != per) begin per = v[i].per; tcnt = 0; end
      obs(g, y, nr, n, clks, ps, psf, bad);
      chk($sformatf("v%0d_green", i), g, v[i].g);
      chk($sformatf("v%0d_yellow", i), y, v[i].y);
      chk($sformatf("v%0d_next_road", i), nr, v[i].nr);
      chk($sformatf("v%0d_ticks", i), n, v[i].ticks);
      chk($sformatf("v%0d_ps_count", i), ps, v[i].g != 0);
      chk($sformatf("v%0d_ps_first", i), psf, v[i].g != 0);
      chk($sformatf("v%0d_lights_ok", i), bad, 0);
      if (v[i].cc) chk($sformatf("v%0d_clocks", i), clks, 5 * v[i].ticks);
    end
    per = 1; tcnt = 0;
    repeat (5) obs(g, y, nr, n, clks, ps, psf, bad);
    chk("pre_reset_yellow", yellow, 4'b0100);
    tick = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_rst();
    reset = 1'b0; tcnt = 0;
    obs(g, y, nr, n, clks, ps, psf, bad);
    chk("post_reset_allred_ticks", n, 2);
    chk("post_reset_green", green, 4'b0001);
    avg_n = 8'd20; avg_e = 8'd0; avg_s = 8'd20; avg_w = 8'd20;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_e%0d", i), next_road, seq_e[i]);
      repeat (3) obs(g, y, nr, n, clks, ps, psf, bad);
    end
    avg_n = 8'd0; avg_e = 8'd0; avg_s = 8'd0; avg_w = 8'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_z%0d", i), next_road, seq_z[i]);
      repeat (3) obs(g, y, nr, n, clks, ps, psf, bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
